alarm_time_setter: RTL and testbench
====================================

Name: alarm_time_setter

Overview:
- Upstream input stage of Alarm_clock. Turns two raw push-buttons plus a target switch into the BCD digits H_in1/H_in0/M_in1/M_in0 and the single-cycle LD_time / LD_alarm strobes that the clock core consumes.
- Handles debouncing, digit entry with wrap-around, commit and inactivity abort, so the clock core only ever sees legal, stable BCD values and clean one-cycle loads.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronised samples required before a button level change is accepted (≥1).
- TIMEOUT_CYCLES, 1000, cycles without an accepted press in an edit state before the edit aborts (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_edit  in  1  raw (asynchronous, bouncing) edit/advance button, active-high.
- btn_up  in  1  raw increment button, active-high.
- sel_alarm  in  1  target switch: 0 = time, 1 = alarm. Sampled only on entry to EDIT_HR.
- H_in1  out  2  hour tens BCD (0..2).
- H_in0  out  4  hour units BCD (0..9).
- M_in1  out  4  minute tens BCD (0..5).
- M_in0  out  4  minute units BCD (0..9).
- LD_time  out  1  one-cycle load strobe for current time.
- LD_alarm  out  1  one-cycle load strobe for alarm time.
- edit_active  out  1  high in EDIT_HR / EDIT_MIN.
- edit_field  out  1  0 = hours being edited, 1 = minutes. Value is 0 outside edit.

Behaviour:
- Reset: state IDLE. Hour = 0, minute = 0, so all digit outputs are 0. LD_time = LD_alarm = edit_active = edit_field = 0. Target = time. Debouncers are cleared to released and their counters to 0. Reset applied mid-edit abandons the edit with no strobe.
- Debounce, per button:
  - 2-flop synchroniser.
  - Stable level changes only after the synchronised value differs from it for DEB_CYCLES consecutive cycles. Any return to the stable value clears the counter.
  - Press = registered one-cycle pulse on a stable 0→1 transition.
  - Raw rising edge at cycle t, held clean, gives a press pulse at cycle t+DEB_CYCLES+3.
  - Glitches shorter than DEB_CYCLES produce no press. Release generates nothing.
- Internal registers: hour (0..23), minute (0..59). Digit outputs are registered BCD derived from them and update in the cycle after hour/minute change. Digits stay stable at all other times and retain their values between sessions.
- FSM:
  - IDLE: edit press → EDIT_HR and latch sel_alarm as target. Up press is ignored.
  - EDIT_HR: up press → hour = (hour==23) ? 0 : hour+1. Edit press → EDIT_MIN.
  - EDIT_MIN: up press → minute = (minute==59) ? 0 : minute+1. Edit press → COMMIT.
  - COMMIT (1 cycle): assert LD_time if target = time, else LD_alarm. Then → IDLE.
  - Strobe timing: the strobe is high exactly one cycle, one cycle after the final edit press. Digit outputs are already valid and unchanged in that cycle.
- Simultaneous edit and up presses in one cycle: edit wins and up is discarded.
- Timeout:
  - The idle counter resets on every accepted press and on entry to EDIT_HR.
  - When it reaches TIMEOUT_CYCLES in EDIT_HR/EDIT_MIN → IDLE with no strobe. Hour/minute keep the edited values, which are not loaded.
- LD_time and LD_alarm are never high together and are never high outside COMMIT.
- sel_alarm changes during an edit have no effect.

Decomposition:
- Package alarm_set_pkg:
  - state enum {IDLE, EDIT_HR, EDIT_MIN, COMMIT}.
  - Constants HOUR_MAX = 23, MIN_MAX = 59.
  - Binary-to-BCD helper function for 0..59.
- Sub-module btn_debounce (param DEB_CYCLES; ports clk, reset, raw, press), instantiated twice.
- Top holds the FSM, the counters and the BCD output registers.

Test Plan:
- Reset then idle 50 cycles → all digits 0, no strobes. Up presses in IDLE → no change.
- sel_alarm=0. Edit, up×10, edit, up×28, edit → digits 1,0,2,8; LD_time high exactly 1 cycle, one cycle after the 3rd edit press; LD_alarm stays 0.
- Wrap: hour at 23, up → 0 (H_in1=0, H_in0=0). Minute at 59, up → 00. sel_alarm=1 commit → LD_alarm only.
- Bounce: btn_up toggling with 1–3-cycle pulses (DEB_CYCLES=4), then held 10 cycles → exactly one increment, press at edge+7.
- Timeout: enter edit, no presses for TIMEOUT_CYCLES → edit_active falls, no strobe. Next edit press restarts at EDIT_HR.
- Reset asserted in EDIT_MIN → IDLE, digits 0, no strobe. Simultaneous edit+up in EDIT_HR → advances to EDIT_MIN, hour unchanged.

Source files
------------

// File: rtl/alarm_set_pkg.sv
// Shared types, limits and BCD helpers for the alarm/time entry front end.
package alarm_set_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        COMMIT   = 2'd3
    } state_e;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    // Binary 0..59 to {tens, units} BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] bin);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(bin / 6'd10);
        units = 4'(bin - (bin / 6'd10) * 6'd10);
        return {tens, units};
    endfunction

    // Hours only reach 23, so the tens digit fits in two bits.
    function automatic logic [5:0] hour_to_bcd(input logic [4:0] hour);
        logic [1:0] tens;
        logic [3:0] units;
        if (hour >= 5'd20) begin
            tens  = 2'd2;
            units = 4'(hour - 5'd20);
        end else if (hour >= 5'd10) begin
            tens  = 2'd1;
            units = 4'(hour - 5'd10);
        end else begin
            tens  = 2'd0;
            units = 4'(hour);
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronise a raw push-button, filter bounces and emit a one-cycle
// registered pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Synchroniser, stability counter and rising-edge press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= '0;
            press_r    <= 1'b0;
        end else begin
            sync1_r    <= raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            if (sync2_r != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= sync2_r;
                    cnt_r    <= '0;
                end else begin
                    cnt_r    <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven HH:MM entry: debounced presses step an edit FSM that commits
// the entered digits to the clock core with a single-cycle load strobe.
module alarm_time_setter
    import alarm_set_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_up,
    input  logic       sel_alarm,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       edit_active,
    output logic       edit_field
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          edit_press_s;
    logic          up_press_s;
    logic [5:0]    hour_bcd_s;
    logic [7:0]    min_bcd_s;

    state_e        state_r;
    logic [4:0]    hour_r;
    logic [5:0]    minute_r;
    logic          target_r;
    logic [TW-1:0] idle_cnt_r;
    logic          ld_time_r;
    logic          ld_alarm_r;
    logic          edit_active_r;
    logic          edit_field_r;
    logic [1:0]    h1_r;
    logic [3:0]    h0_r;
    logic [3:0]    m1_r;
    logic [3:0]    m0_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_edit (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_edit),
        .press (edit_press_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_up),
        .press (up_press_s)
    );

    // Edit FSM with hour/minute counters, inactivity timer and load strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            hour_r        <= 5'd0;
            minute_r      <= 6'd0;
            target_r      <= 1'b0;
            idle_cnt_r    <= '0;
            ld_time_r     <= 1'b0;
            ld_alarm_r    <= 1'b0;
            edit_active_r <= 1'b0;
            edit_field_r  <= 1'b0;
        end else begin
            ld_time_r  <= 1'b0;
            ld_alarm_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (edit_press_s) begin
                        state_r       <= EDIT_HR;
                        target_r      <= sel_alarm;
                        idle_cnt_r    <= '0;
                        edit_active_r <= 1'b1;
                        edit_field_r  <= 1'b0;
                    end
                end
                EDIT_HR: begin
                    // Edit is tested first so a coincident up press is dropped.
                    if (edit_press_s) begin
                        state_r      <= EDIT_MIN;
                        idle_cnt_r   <= '0;
                        edit_field_r <= 1'b1;
                    end else if (up_press_s) begin
                        hour_r     <= (hour_r == HOUR_MAX) ? 5'd0 : hour_r + 5'd1;
                        idle_cnt_r <= '0;
                    end else if (idle_cnt_r == TO_LAST) begin
                        state_r       <= IDLE;
                        idle_cnt_r    <= '0;
                        edit_active_r <= 1'b0;
                        edit_field_r  <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TW'(1);
                    end
                end
                EDIT_MIN: begin
                    if (edit_press_s) begin
                        state_r       <= COMMIT;
                        idle_cnt_r    <= '0;
                        edit_active_r <= 1'b0;
                        edit_field_r  <= 1'b0;
                        ld_time_r     <= ~target_r;
                        ld_alarm_r    <= target_r;
                    end else if (up_press_s) begin
                        minute_r   <= (minute_r == MIN_MAX) ? 6'd0 : minute_r + 6'd1;
                        idle_cnt_r <= '0;
                    end else if (idle_cnt_r == TO_LAST) begin
                        state_r       <= IDLE;
                        idle_cnt_r    <= '0;
                        edit_active_r <= 1'b0;
                        edit_field_r  <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TW'(1);
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    edit_active_r <= 1'b0;
                    edit_field_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hour_bcd_s = hour_to_bcd(hour_r);
    assign min_bcd_s  = bin_to_bcd(minute_r);

    // BCD digit registers trail the binary counters by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            h1_r <= 2'd0;
            h0_r <= 4'd0;
            m1_r <= 4'd0;
            m0_r <= 4'd0;
        end else begin
            h1_r <= hour_bcd_s[5:4];
            h0_r <= hour_bcd_s[3:0];
            m1_r <= min_bcd_s[7:4];
            m0_r <= min_bcd_s[3:0];
        end
    end

    assign H_in1       = h1_r;
    assign H_in0       = h0_r;
    assign M_in1       = m1_r;
    assign M_in0       = m0_r;
    assign LD_time     = ld_time_r;
    assign LD_alarm    = ld_alarm_r;
    assign edit_active = edit_active_r;
    assign edit_field  = edit_field_r;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Self-checking bench: press-sequence vector table plus hand-written bounce,
// timeout and mid-edit reset sequences; load strobes go through a scoreboard.
module tb_alarm_time_setter;

    localparam int DEB = 4;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_edit;
    logic       btn_up;
    logic       sel_alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       edit_active;
    logic       edit_field;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit prev_ld = 1'b0;

    typedef struct {
        bit e;
        bit u;
        int n;
        bit sel;
        int strobe;   // 0 none, 1 time, 2 alarm (on the last press of the record)
        int h;
        int m;
        bit act;
        bit fld;
    } vec_t;

    typedef struct {
        int cyc;
        bit alarm;
        int h;
        int m;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_x;

    alarm_time_setter #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_edit    (btn_edit),
        .btn_up      (btn_up),
        .sel_alarm   (sel_alarm),
        .H_in1       (H_in1),
        .H_in0       (H_in0),
        .M_in1       (M_in1),
        .M_in0       (M_in0),
        .LD_time     (LD_time),
        .LD_alarm    (LD_alarm),
        .edit_active (edit_active),
        .edit_field  (edit_field)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] bcd_of(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [13:0] digits();
        return {H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one clean press; push the expected strobe before it can appear.
    task automatic press(input bit e, input bit u, input bit sel, input int strobe,
                         input int h, input int m);
        exp_t x;
        @(posedge clk); #1;
        sel_alarm = sel;
        btn_edit  = e;
        btn_up    = u;
        if (strobe != 0) begin
            x.cyc   = cyc + DEB + 4;
            x.alarm = (strobe == 2);
            x.h     = h;
            x.m     = m;
            sb.push_back(x);
        end
        repeat (8) @(posedge clk);
        #1;
        btn_edit = 1'b0;
        btn_up   = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (LD_time || LD_alarm) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: LD_time=%0b LD_alarm=%0b at cycle %0d, expected no strobe",
                         LD_time, LD_alarm, cyc);
            end else begin
                mon_x = sb.pop_front();
                if (cyc != mon_x.cyc || LD_time != !mon_x.alarm || LD_alarm != mon_x.alarm ||
                    digits() != bcd_of(mon_x.h, mon_x.m) || prev_ld) begin
                    errors++;
                    $display("FAIL strobe: cycle %0d LD_time=%0b LD_alarm=%0b digits=0x%0h prev=%0b, expected cycle %0d alarm=%0b digits=0x%0h prev=0",
                             cyc, LD_time, LD_alarm, digits(), prev_ld, mon_x.cyc, mon_x.alarm,
                             bcd_of(mon_x.h, mon_x.m));
                end
            end
        end
        prev_ld <= LD_time | LD_alarm;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hi[5];
        int lo[5];
        hi = '{1, 3, 2, 1, 3};
        lo = '{1, 2, 1, 1, 2};

        vecs.push_back('{1'b0, 1'b1, 3,  1'b0, 0, 0,  0,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 0, 0,  0,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 10, 1'b0, 0, 10, 0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 0, 10, 0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 28, 1'b0, 0, 10, 28, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 1, 10, 28, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b1, 0, 10, 28, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 13, 1'b0, 0, 23, 28, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 0, 0,  28, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 0, 0,  28, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 31, 1'b0, 0, 0,  59, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 0, 0,  0,  1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 2, 0,  0,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 0, 0,  0,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 5,  1'b0, 0, 5,  0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1,  1'b0, 0, 5,  0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 2,  1'b0, 0, 5,  2,  1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 1, 5,  2,  1'b0, 1'b0});

        reset = 1'b1; btn_edit = 1'b0; btn_up = 1'b0; sel_alarm = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_digits", 32'(digits()), 32'(bcd_of(0, 0)));
        chk("reset_active", 32'(edit_active), 32'd0);
        chk("reset_field",  32'(edit_field),  32'd0);
        chk("reset_ld",     32'({LD_time, LD_alarm}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("idle_digits", 32'(digits()), 32'(bcd_of(0, 0)));
        chk("idle_active", 32'(edit_active), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                press(vecs[i].e, vecs[i].u, vecs[i].sel, (k == vecs[i].n - 1) ? vecs[i].strobe : 0,
                      vecs[i].h, vecs[i].m);
            @(negedge clk);
            chk($sformatf("vec%0d_digits", i), 32'(digits()), 32'(bcd_of(vecs[i].h, vecs[i].m)));
            chk($sformatf("vec%0d_active", i), 32'(edit_active), 32'(vecs[i].act));
            chk($sformatf("vec%0d_field", i),  32'(edit_field),  32'(vecs[i].fld));
        end

        // Bounce: short glitches then one clean hold -> one increment at edge+DEB+4
        press(1'b1, 1'b0, 1'b0, 0, 5, 2);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1;
            repeat (hi[i]) @(posedge clk);
            #1;
            btn_up = 1'b0;
            repeat (lo[i]) @(posedge clk);
            #1;
        end
        btn_up = 1'b1;
        c = cyc;
        while (cyc != c + DEB + 4) @(negedge clk);
        chk("bounce_before", 32'(digits()), 32'(bcd_of(5, 2)));
        @(negedge clk);
        chk("bounce_after", 32'(digits()), 32'(bcd_of(6, 2)));
        repeat (2) @(posedge clk);
        #1;
        btn_up = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bounce_single", 32'(digits()), 32'(bcd_of(6, 2)));

        // Timeout: last press acted on at edge c+DEB+4, abort TO edges later
        while (cyc != c + DEB + 3 + TO) @(negedge clk);
        chk("timeout_before", 32'(edit_active), 32'd1);
        @(negedge clk);
        chk("timeout_active", 32'(edit_active), 32'd0);
        chk("timeout_field",  32'(edit_field),  32'd0);
        chk("timeout_keep",   32'(digits()), 32'(bcd_of(6, 2)));

        press(1'b1, 1'b0, 1'b0, 0, 6, 2);
        @(negedge clk);
        chk("restart_hr_active", 32'(edit_active), 32'd1);
        chk("restart_hr_field",  32'(edit_field),  32'd0);
        press(1'b1, 1'b0, 1'b0, 0, 6, 2);
        press(1'b0, 1'b1, 1'b0, 0, 6, 3);
        press(1'b0, 1'b1, 1'b0, 0, 6, 4);
        @(negedge clk);
        chk("min_edit_field",  32'(edit_field), 32'd1);
        chk("min_edit_digits", 32'(digits()), 32'(bcd_of(6, 4)));

        // Reset in EDIT_MIN abandons the edit with no strobe
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_digits", 32'(digits()), 32'(bcd_of(0, 0)));
        chk("midreset_active", 32'(edit_active), 32'd0);
        chk("midreset_field",  32'(edit_field),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("post_reset_digits", 32'(digits()), 32'(bcd_of(0, 0)));
        chk("post_reset_active", 32'(edit_active), 32'd0);
        chk("scoreboard_empty",  32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
